fetch_seq: RTL and testbench

//  Fetch sequencer that owns the program counter. It issues one instruction-memory request at a

---
 rtl/fetch_seq_pkg.sv | 20 ++
 rtl/fetch_seq_npc_sel.sv | 27 ++
 rtl/fetch_seq.sv | 130 +++++++++++++
 tb/tb_fetch_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding, instruction
// size and default reset/trap vectors.
// Optional feature macro: FETCH_SEQ_MISALIGN_TRAP_EN (adds the trap vector default).
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    FS_IDLE  = 3'd0,
    FS_REQ   = 3'd1,
    FS_WAIT  = 3'd2,
    FS_DRAIN = 3'd3,
    FS_HOLD  = 3'd4
  } fs_state_t;

  localparam int unsigned INSTR_BYTES  = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
  localparam logic [31:0] DEF_TRAP_PC  = 32'h0000_0080;
`endif

endpackage

// File: rtl/fetch_seq_npc_sel.sv
// Next-PC selection for the fetch sequencer. Pure combinational mux over
// {hold, pc+4, redirect target, trap vector} with priority redir > advance > hold.
// A redirect target always has its two low bits cleared; the trap vector is
// chosen instead when the caller flags the redirect as misaligned.
module fetch_seq_npc_sel
  import fetch_seq_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] redir_target,
  input  logic [31:0] trap_pc,
  input  logic        redir,
  input  logic        trap,
  input  logic        advance,
  output logic [31:0] npc
);

  // Redirect wins over the sequential advance; otherwise the PC holds.
  always_comb begin
    npc = pc;
    if (redir) begin
      npc = trap ? trap_pc : (redir_target & ~32'h0000_0003);
    end else if (advance) begin
      npc = pc + 32'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: owns the PC, issues one instruction-memory request at a time
// (req/gnt + rvalid) and hands each instruction with its PC to decode
// (valid/ready). Redirects from execute take priority and squash in-flight fetches.
// Optional feature macro: FETCH_SEQ_MISALIGN_TRAP_EN -- misaligned redirect
// targets load TRAP_PC and pulse the misalign output.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
  ,
  parameter logic [31:0] TRAP_PC  = DEF_TRAP_PC
`endif
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  input  logic        halt
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  fs_state_t   state;
  logic [31:0] pc;
  logic [31:0] addr_q;
  logic        squash;
  logic [31:0] npc;
  logic        advance;
  logic        trap;
  logic [31:0] trap_pc;

`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
  assign trap    = redir_valid & (redir_target[1:0] != 2'b00);
  assign trap_pc = TRAP_PC;
`else
  assign trap    = 1'b0;
  assign trap_pc = 32'h0000_0000;
`endif

  // Sequential advance only when decode takes the held instruction.
  assign advance = (state == FS_HOLD) && if_ready;

  fetch_seq_npc_sel u_npc_sel (
    .pc           (pc),
    .redir_target (redir_target),
    .trap_pc      (trap_pc),
    .redir        (redir_valid),
    .trap         (trap),
    .advance      (advance),
    .npc          (npc)
  );

  // Handshake flags decode straight from the state register.
  assign imem_req  = (state == FS_REQ);
  assign if_valid  = (state == FS_HOLD);
  assign imem_addr = addr_q;

  // Fetch FSM, PC and fetch-address registers. The fetch address follows the
  // PC except while an ungranted request is pending, so a redirect in REQ
  // lets the original address complete and marks it for squashing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FS_IDLE;
      pc       <= RESET_PC;
      addr_q   <= RESET_PC;
      squash   <= 1'b0;
      if_instr <= 32'h0000_0000;
      if_pc    <= 32'h0000_0000;
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
    end else begin
      pc <= npc;
      if (!((state == FS_REQ) && !imem_gnt)) begin
        addr_q <= npc;
      end
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
      misalign <= trap;
`endif
      case (state)
        FS_IDLE: begin
          if (!halt) state <= FS_REQ;
        end
        FS_REQ: begin
          if (imem_gnt) begin
            state <= (squash || redir_valid) ? FS_DRAIN : FS_WAIT;
          end else if (redir_valid) begin
            squash <= 1'b1;
          end
        end
        FS_WAIT: begin
          if (redir_valid) begin
            state <= imem_rvalid ? FS_REQ : FS_DRAIN;
          end else if (imem_rvalid) begin
            if_instr <= imem_rdata;
            if_pc    <= pc;
            state    <= FS_HOLD;
          end
        end
        FS_DRAIN: begin
          if (imem_rvalid) begin
            squash <= 1'b0;
            state  <= (halt && !redir_valid) ? FS_IDLE : FS_REQ;
          end
        end
        FS_HOLD: begin
          if (redir_valid) begin
            state <= FS_REQ;
          end else if (if_ready) begin
            state <= halt ? FS_IDLE : FS_REQ;
          end
        end
        default: state <= FS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: a cycle-by-cycle vector table covering
// sequential fetch, hold, halt, redirects in every state, squash and PC wrap,
// followed by hand-written sequences for async reset and misaligned redirects.
module tb_fetch_seq;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        halt;
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
  logic        misalign;
  localparam logic [31:0] EXP_MIS = 32'h0000_0080;
`else
  localparam logic [31:0] EXP_MIS = 32'h0000_0100;
`endif

  int checks;
  int errors;

  fetch_seq #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .if_ready     (if_ready),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .halt         (halt)
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
    ,
    .misalign     (misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        redir;
    logic [31:0] tgt;
    logic        hlt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic g, input logic rv, input logic [31:0] rd,
                     input logic rdy, input logic rdr, input logic [31:0] tg,
                     input logic h, input logic er, input logic [31:0] ea,
                     input logic ev, input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.gnt = g;  v.rv = rv;  v.rdata = rd; v.rdy = rdy; v.redir = rdr;
    v.tgt = tg; v.hlt = h;  v.e_req = er; v.e_addr = ea; v.e_vld = ev;
    v.e_instr = ei; v.e_pc = ep;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic rdr, input logic [31:0] tg,
                       input logic h);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd; if_ready = rdy;
    redir_valid = rdr; redir_target = tg; halt = h;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    //  gnt rv rdata         rdy rdr tgt           h | req addr          vld instr         pc
    add(0, 0, 32'h0,        0, 0, 32'h0,        0,  1, 32'h0,         0, 32'h0,        32'h0);
    add(1, 0, 32'h0,        0, 0, 32'h0,        0,  0, 32'h0,         0, 32'h0,        32'h0);
    add(0, 1, 32'h13,       0, 0, 32'h0,        0,  0, 32'h0,         1, 32'h13,       32'h0);
    add(0, 0, 32'h0,        1, 0, 32'h0,        0,  1, 32'h4,         0, 32'h13,       32'h0);
    add(1, 0, 32'h0,        0, 0, 32'h0,        0,  0, 32'h4,         0, 32'h13,       32'h0);
    add(0, 1, 32'h00100093, 0, 0, 32'h0,        0,  0, 32'h4,         1, 32'h00100093, 32'h4);
    add(0, 0, 32'h0,        1, 0, 32'h0,        0,  1, 32'h8,         0, 32'h00100093, 32'h4);
    add(1, 0, 32'h0,        0, 0, 32'h0,        0,  0, 32'h8,         0, 32'h00100093, 32'h4);
    add(0, 1, 32'h00200113, 0, 0, 32'h0,        0,  0, 32'h8,         1, 32'h00200113, 32'h8);
    add(0, 0, 32'h0,        0, 0, 32'h0,        0,  0, 32'h8,         1, 32'h00200113, 32'h8);
    add(0, 0, 32'h0,        1, 0, 32'h0,        1,  0, 32'hC,         0, 32'h00200113, 32'h8);
    add(0, 0, 32'h0,        0, 0, 32'h0,        1,  0, 32'hC,         0, 32'h00200113, 32'h8);
    add(0, 0, 32'h0,        0, 0, 32'h0,        0,  1, 32'hC,         0, 32'h00200113, 32'h8);
    add(1, 0, 32'h0,        0, 0, 32'h0,        0,  0, 32'hC,         0, 32'h00200113, 32'h8);
    add(0, 1, 32'hDEADBEEF, 0, 1, 32'h100,      0,  1, 32'h100,       0, 32'h00200113, 32'h8);
    add(1, 0, 32'h0,        0, 0, 32'h0,        0,  0, 32'h100,       0, 32'h00200113, 32'h8);
    add(0, 0, 32'h0,        0, 1, 32'h200,      0,  0, 32'h200,       0, 32'h00200113, 32'h8);
    add(0, 1, 32'h0BAD0BAD, 0, 0, 32'h0,        0,  1, 32'h200,       0, 32'h00200113, 32'h8);
    add(1, 0, 32'h0,        0, 0, 32'h0,        0,  0, 32'h200,       0, 32'h00200113, 32'h8);
    add(0, 1, 32'h33,       0, 0, 32'h0,        0,  0, 32'h200,       1, 32'h33,       32'h200);
    add(0, 0, 32'h0,        1, 1, 32'h300,      0,  1, 32'h300,       0, 32'h33,       32'h200);
    add(0, 0, 32'h0,        0, 1, 32'h400,      0,  1, 32'h300,       0, 32'h33,       32'h200);
    add(1, 0, 32'h0,        0, 0, 32'h0,        0,  0, 32'h400,       0, 32'h33,       32'h200);
    add(0, 1, 32'h11111111, 0, 0, 32'h0,        0,  1, 32'h400,       0, 32'h33,       32'h200);
    add(1, 0, 32'h0,        0, 0, 32'h0,        0,  0, 32'h400,       0, 32'h33,       32'h200);
    add(0, 1, 32'h22222222, 0, 0, 32'h0,        0,  0, 32'h400,       1, 32'h22222222, 32'h400);
    add(0, 0, 32'h0,        1, 0, 32'h0,        0,  1, 32'h404,       0, 32'h22222222, 32'h400);
    add(1, 0, 32'h0,        0, 0, 32'h0,        0,  0, 32'h404,       0, 32'h22222222, 32'h400);
    add(0, 1, 32'h55555555, 0, 1, 32'hFFFFFFFC, 0,  1, 32'hFFFFFFFC,  0, 32'h22222222, 32'h400);
    add(1, 0, 32'h0,        0, 0, 32'h0,        0,  0, 32'hFFFFFFFC,  0, 32'h22222222, 32'h400);
    add(0, 1, 32'h44,       0, 0, 32'h0,        0,  0, 32'hFFFFFFFC,  1, 32'h44,       32'hFFFFFFFC);
    add(0, 0, 32'h0,        1, 0, 32'h0,        0,  1, 32'h0,         0, 32'h44,       32'hFFFFFFFC);
    add(0, 0, 32'h0,        0, 1, 32'h102,      0,  1, 32'h0,         0, 32'h44,       32'hFFFFFFFC);
    add(1, 0, 32'h0,        0, 0, 32'h0,        0,  0, EXP_MIS,       0, 32'h44,       32'hFFFFFFFC);
    add(0, 1, 32'h66666666, 0, 0, 32'h0,        0,  1, EXP_MIS,       0, 32'h44,       32'hFFFFFFFC);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   {31'h0, imem_req}, 32'h0);
    chk("rst_vld",   {31'h0, if_valid}, 32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_instr", if_instr,  32'h0);
    chk("rst_pc",    if_pc,     32'h0);

    // Release and run the vector table; inputs change on the falling edge.
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].rdy, tbl[i].redir,
            tbl[i].tgt, tbl[i].hlt);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_req", i),   {31'h0, imem_req}, {31'h0, tbl[i].e_req});
      chk($sformatf("v%0d_addr", i),  imem_addr,         tbl[i].e_addr);
      chk($sformatf("v%0d_vld", i),   {31'h0, if_valid}, {31'h0, tbl[i].e_vld});
      chk($sformatf("v%0d_instr", i), if_instr,          tbl[i].e_instr);
      chk($sformatf("v%0d_pc", i),    if_pc,             tbl[i].e_pc);
      @(negedge clk);
    end

    // Async reset while WAIT is outstanding: outputs clear without a clock edge.
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("arst_req",   {31'h0, imem_req}, 32'h0);
    chk("arst_vld",   {31'h0, if_valid}, 32'h0);
    chk("arst_addr",  imem_addr, 32'h0);
    chk("arst_instr", if_instr,  32'h0);
    chk("arst_pc",    if_pc,     32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_req",  {31'h0, imem_req}, 32'h1);
    chk("rel_addr", imem_addr, 32'h0);

    // Misaligned redirect granted in REQ: drained, next request at the
    // trap vector (feature on) or the aligned target (feature off).
    @(negedge clk);
    drive(1, 0, 0, 0, 1, 32'h102, 0);
    @(posedge clk);
    #1;
    chk("mis_req0",  {31'h0, imem_req}, 32'h0);
    chk("mis_addr0", imem_addr, EXP_MIS);
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
    chk("mis_pulse", {31'h0, misalign}, 32'h1);
`endif
    @(negedge clk);
    drive(0, 1, 32'h77777777, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("mis_req1",  {31'h0, imem_req}, 32'h1);
    chk("mis_addr1", imem_addr, EXP_MIS);
    chk("mis_vld",   {31'h0, if_valid}, 32'h0);
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
    chk("mis_end",   {31'h0, misalign}, 32'h0);
`endif
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
